// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_L = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } owner_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/imem_arb_timeout.sv
// Loadable countdown timer; expire is high during the last permitted wait cycle.
module imem_arb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic tick,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT);
    end else if (clr) begin
      count <= '0;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CW'(1));

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter between IF fetch and loader/debug port.
// Optional fetch starvation guard: define IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_instr,
  output logic              f_valid,
  output logic              f_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("imem_arbiter: TIMEOUT must be at least 1");
  end
  if (MAX_CONSEC < 1) begin : g_bad_max_consec
    $error("imem_arbiter: MAX_CONSEC must be at least 1");
  end

  arb_state_t state;
  owner_t     owner;
  logic       busy;
  logic       f_cand;
  logic       force_fetch;
  logic       grant_l;
  logic       grant_f;
  logic       expire;

  assign busy    = (state == BUSY_F) || (state == BUSY_L);
  assign owner   = (state == BUSY_L) ? LOADER : FETCH;
  assign f_stall = f_req & ~f_valid;
  // During its valid cycle the held f_req still belongs to the finished fetch.
  assign f_cand  = f_req & ~f_valid;
  assign grant_l = (state == IDLE) & l_req & ~force_fetch;
  assign grant_f = (state == IDLE) & f_cand & ~grant_l;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_CONSEC + 1);
  logic [SW-1:0] starve_cnt;

  assign force_fetch = f_cand && (starve_cnt >= SW'(MAX_CONSEC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_f || !f_req) begin
        starve_cnt <= '0;
      end else if (grant_l && starve_cnt < SW'(MAX_CONSEC)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  imem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant_l | grant_f),
    .tick    (busy),
    .clr     (busy & m_ack),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      f_instr <= '0;
      f_valid <= 1'b0;
      l_rdata <= '0;
      l_valid <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      l_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_l) begin
            state   <= BUSY_L;
            m_req   <= 1'b1;
            m_we    <= l_we;
            m_addr  <= l_addr;
            m_wdata <= l_wdata;
          end else if (grant_f) begin
            state   <= BUSY_F;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= f_addr;
          end
        end
        BUSY_F, BUSY_L: begin
          // Ack takes precedence over a timeout landing on the same cycle.
          if (m_ack) begin
            state <= IDLE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            if (owner == FETCH) begin
              f_instr <= m_rdata;
              f_valid <= 1'b1;
            end else begin
              if (!m_we) l_rdata <= m_rdata;
              l_valid <= 1'b1;
            end
          end else if (expire) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            bus_err <= 1'b1;
            if (owner == FETCH) begin
              f_instr <= DATA_W'(NOP_INSTR);
              f_valid <= 1'b1;
            end else begin
              l_rdata <= '0;
              l_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter (default TIMEOUT=16, MAX_CONSEC=4).
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req, l_req, l_we, m_ack;
  logic [31:0] f_addr, l_addr, l_wdata, m_rdata;
  logic [31:0] f_instr, l_rdata, m_addr, m_wdata;
  logic        f_valid, f_stall, l_valid, m_req, m_we, bus_err;

  int passed = 0;
  int total  = 0;

  imem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_instr (f_instr),
    .f_valid (f_valid),
    .f_stall (f_stall),
    .l_req   (l_req),
    .l_we    (l_we),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_rdata (l_rdata),
    .l_valid (l_valid),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    f_req = 0; l_req = 0; l_we = 0; m_ack = 0;
    f_addr = 0; l_addr = 0; l_wdata = 0; m_rdata = 0;
    tick(); tick();
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_m_we", {31'b0, m_we}, 32'd0);
    check("rst_valids", {29'b0, f_valid, l_valid, bus_err}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_f_instr", f_instr, 32'd0);
    check("rst_l_rdata", l_rdata, 32'd0);
    check("rst_f_stall", {31'b0, f_stall}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single fetch, memory acks in first BUSY cycle
    f_req = 1; f_addr = 32'h100;
    #1 check("f1_stall_req", {31'b0, f_stall}, 32'd1);
    tick();
    check("f1_m_req", {31'b0, m_req}, 32'd1);
    check("f1_m_addr", m_addr, 32'h100);
    check("f1_m_we", {31'b0, m_we}, 32'd0);
    m_ack = 1; m_rdata = 32'h00500093;
    tick();
    check("f1_valid", {31'b0, f_valid}, 32'd1);
    check("f1_instr", f_instr, 32'h00500093);
    check("f1_stall_low", {31'b0, f_stall}, 32'd0);
    check("f1_m_req_drop", {31'b0, m_req}, 32'd0);
    m_ack = 0; f_req = 0;
    tick();
    check("f1_valid_pulse", {31'b0, f_valid}, 32'd0);
    check("f1_idle", {31'b0, m_req}, 32'd0);

    // Simultaneous requests: loader write first, then fetch
    f_req = 1; f_addr = 32'h104;
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'hDEADBEEF;
    tick();
    check("sim_l_m_addr", m_addr, 32'h40);
    check("sim_l_m_we", {31'b0, m_we}, 32'd1);
    check("sim_l_m_wdata", m_wdata, 32'hDEADBEEF);
    check("sim_stall_a", {31'b0, f_stall}, 32'd1);
    tick();
    check("sim_wait_m_req", {31'b0, m_req}, 32'd1);
    check("sim_stall_b", {31'b0, f_stall}, 32'd1);
    m_ack = 1; m_rdata = 32'hAAAA5555;
    tick();
    check("sim_l_valid", {31'b0, l_valid}, 32'd1);
    check("sim_wr_rdata_kept", l_rdata, 32'd0);
    check("sim_stall_c", {31'b0, f_stall}, 32'd1);
    check("sim_no_f_valid", {31'b0, f_valid}, 32'd0);
    m_ack = 0; l_req = 0; l_we = 0;
    tick();
    check("sim_f_grant", {31'b0, m_req}, 32'd1);
    check("sim_f_m_addr", m_addr, 32'h104);
    check("sim_f_m_we", {31'b0, m_we}, 32'd0);
    check("sim_l_valid_pulse", {31'b0, l_valid}, 32'd0);
    m_ack = 1; m_rdata = 32'h00000517;
    tick();
    check("sim_f_valid", {31'b0, f_valid}, 32'd1);
    check("sim_f_instr", f_instr, 32'h00000517);
    m_ack = 0; f_req = 0;
    tick();

    // Loader read returns data
    l_req = 1; l_we = 0; l_addr = 32'h80;
    tick();
    check("lr_m_addr", m_addr, 32'h80);
    m_ack = 1; m_rdata = 32'hCAFEF00D;
    tick();
    check("lr_valid", {31'b0, l_valid}, 32'd1);
    check("lr_rdata", l_rdata, 32'hCAFEF00D);
    m_ack = 0; l_req = 0;
    tick();

    // Fetch timeout: no ack for 16 BUSY cycles
    f_req = 1; f_addr = 32'h200;
    tick();
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_wait_m_req", {31'b0, m_req}, 32'd1);
    end
    check("to_no_early_err", {31'b0, bus_err}, 32'd0);
    tick();
    check("to_bus_err", {31'b0, bus_err}, 32'd1);
    check("to_f_valid", {31'b0, f_valid}, 32'd1);
    check("to_nop", f_instr, 32'h00000013);
    check("to_m_req_low", {31'b0, m_req}, 32'd0);
    f_req = 0;
    tick();
    check("to_err_pulse", {31'b0, bus_err}, 32'd0);
    check("to_idle", {31'b0, m_req}, 32'd0);

    // Ack arriving on the 16th BUSY cycle wins over timeout
    f_req = 1; f_addr = 32'h300;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    m_ack = 1; m_rdata = 32'h12345678;
    tick();
    check("col_f_valid", {31'b0, f_valid}, 32'd1);
    check("col_f_instr", f_instr, 32'h12345678);
    check("col_no_err", {31'b0, bus_err}, 32'd0);
    m_ack = 0; f_req = 0;
    tick();
    check("col_no_late_err", {31'b0, bus_err}, 32'd0);

    // Ack while IDLE is ignored
    m_ack = 1; m_rdata = 32'hFFFFFFFF;
    tick();
    check("idle_ack_valids", {30'b0, f_valid, l_valid}, 32'd0);
    check("idle_ack_instr", f_instr, 32'h12345678);
    m_ack = 0;

    // Reset two cycles into a loader read, fetch pending
    l_req = 1; l_we = 0; l_addr = 32'h400;
    f_req = 1; f_addr = 32'h500;
    tick();
    check("rb_l_grant", m_addr, 32'h400);
    tick();
    reset_n = 1'b0;
    #1;
    check("rb_async_m_req", {31'b0, m_req}, 32'd0);
    check("rb_async_m_addr", m_addr, 32'd0);
    l_req = 0;
    tick();
    check("rb_no_l_valid", {31'b0, l_valid}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rb_f_grant", {31'b0, m_req}, 32'd1);
    check("rb_f_m_addr", m_addr, 32'h500);
    m_ack = 1; m_rdata = 32'h00A00113;
    tick();
    check("rb_f_valid", {31'b0, f_valid}, 32'd1);
    check("rb_f_instr", f_instr, 32'h00A00113);
    check("rb_l_valid_none", {31'b0, l_valid}, 32'd0);
    m_ack = 0; f_req = 0;
    tick();

    // Loader and fetch held high together
    l_req = 1; l_we = 0; l_addr = 32'h600;
    f_req = 1; f_addr = 32'h700;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp_addr;
      tick();
`ifdef IMEM_ARB_STARVE_GUARD_EN
      exp_addr = (i % 5 == 4) ? 32'h700 : 32'h600;
`else
      exp_addr = 32'h600;
`endif
      check("starve_owner", m_addr, exp_addr);
      m_ack = 1; m_rdata = 32'(i);
      tick();
      m_ack = 0;
      if (i == 9) begin
        l_req = 0; f_req = 0;
      end
    end
    tick();
    check("starve_done_idle", {31'b0, m_req}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
